// File: rtl/secuenciador_mult.sv
// Operand FIFO and launch sequencer for the Booth multiplier: queues signed pairs,
// pulses start, waits for the Fin rising edge (or a timeout) and returns the product in order.
module secuenciador_mult #(
    parameter int NUM_BITS   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_BITS-1:0]             in_multiplicando,
    input  logic [NUM_BITS-1:0]             in_multiplicador,
    output logic [NUM_BITS-1:0]             mult_multiplicando,
    output logic [NUM_BITS-1:0]             mult_multiplicador,
    output logic                            mult_start,
    input  logic [2*NUM_BITS-1:0]           mult_resultado,
    input  logic                            mult_fin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*NUM_BITS-1:0]           out_resultado,
    output logic                            out_error,
    output logic [$clog2(FIFO_DEPTH):0]     ocupacion
);

    // state   | meaning
    // IDLE    | waiting for a queued pair; pops the head when one is present
    // LANZA   | mult_start high for this single cycle, timer cleared
    // ESPERA  | waiting for a Fin rising edge or the timeout
    // ENTREGA | result held on out_* until the consumer takes it

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int RW = 2 * NUM_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LANZA   = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [RW-1:0]        mem_q [FIFO_DEPTH];
    logic [RW-1:0]        mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [NUM_BITS-1:0]  mcando_q, mcando_d;
    logic [NUM_BITS-1:0]  mcador_q, mcador_d;
    logic                 start_q, start_d;
    logic                 fin_q, fin_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 valid_q, valid_d;
    logic [RW-1:0]        res_q, res_d;
    logic                 err_q, err_d;

    logic                 push;
    logic                 pop;
    logic                 fin_edge;

    assign in_ready           = (count_q != CW'(FIFO_DEPTH));
    assign push               = in_valid & in_ready;
    assign fin_edge           = mult_fin & ~fin_q;

    assign mult_multiplicando = mcando_q;
    assign mult_multiplicador = mcador_q;
    assign mult_start         = start_q;
    assign out_valid          = valid_q;
    assign out_resultado      = res_q;
    assign out_error          = err_q;
    assign ocupacion          = count_q;

    always_comb begin
        estado_d = estado_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mcando_d = mcando_q;
        mcador_d = mcador_q;
        start_d  = 1'b0;
        fin_d    = mult_fin;
        timer_d  = timer_q;
        valid_d  = valid_q;
        res_d    = res_q;
        err_d    = err_q;
        pop      = 1'b0;

        case (estado_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    mcando_d = mem_q[rd_ptr_q][RW-1:NUM_BITS];
                    mcador_d = mem_q[rd_ptr_q][NUM_BITS-1:0];
                    start_d  = 1'b1;
                    estado_d = LANZA;
                end
            end
            LANZA: begin
                timer_d  = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A real completion takes priority over a timeout in the same cycle.
                if (fin_edge) begin
                    res_d    = mult_resultado;
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                    estado_d = ENTREGA;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    res_d    = '0;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    estado_d = ENTREGA;
                end else begin
                    timer_d  = timer_q + 1'b1;
                end
            end
            ENTREGA: begin
                if (out_ready) begin
                    valid_d  = 1'b0;
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {in_multiplicando, in_multiplicador};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mcando_q <= '0;
            mcador_q <= '0;
            start_q  <= 1'b0;
            fin_q    <= 1'b0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mcando_q <= mcando_d;
            mcador_q <= mcador_d;
            start_q  <= start_d;
            fin_q    <= fin_d;
            timer_q  <= timer_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

endmodule
